mac_alu: RTL and testbench

Parametrised, multi-cycle successor to the picoMips accumulator ALU. It holds a signed fixed-point accumulator `ACC` and executes load, add, subtract, multiply and multiply-accumulate operations, selected by `Func`, on a muxed operand. Multiplies run on a sequential shift-add datapath, and a Start/Busy/Done handshake connects it to the picoMips decoder. Overflow is handled by either saturation or wrap, and is reported on a flag.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/seq_mult.sv | 58 +++++
 rtl/mac_alu.sv | 123 ++++++++++++
 tb/tb_mac_alu.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and the saturate/wrap helper for the mac_alu accumulator ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        LOAD = 3'd1,
        ADD  = 3'd2,
        SUB  = 3'd3,
        MUL  = 3'd4,
        MAC  = 3'd5
    } func_t;

    typedef enum logic {
        IDLE = 1'b0,
        MULT = 1'b1
    } state_t;

    // The result occupies bits [w-1:0] and the overflow flag sits at bit w.
    // A caller can then take both with a single (w+1)-bit size cast.
    function automatic logic [64:0] sat_w(input logic signed [63:0] v,
                                          input int unsigned w,
                                          input bit sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic signed [63:0] clip;
        logic [64:0]        mask;
        logic               ovf;
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -(64'sd1 <<< (w - 1));
        ovf  = (v > hi) || (v < lo);
        clip = v;
        if (sat) begin
            if (v > hi)
                clip = hi;
            else if (v < lo)
                clip = lo;
        end
        mask = (65'd1 << w) - 65'd1;
        return ({1'b0, clip} & mask) | (65'(ovf) << w);
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Radix-2 signed shift-add multiplier; one partial product per clock, WIDTH clocks.
module seq_mult #(
    parameter int WIDTH = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic                      Load,
    input  logic [WIDTH-1:0]          A,
    input  logic [WIDTH-1:0]          B,
    output logic signed [2*WIDTH-1:0] Product,
    output logic                      Valid
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_run;

    logic [2*WIDTH-1:0] w_term;
    logic [2*WIDTH-1:0] w_next;
    logic               w_last;

    // The multiplier MSB carries weight -2^(W-1), so the last partial product is subtracted.
    assign w_term = r_mplier[0] ? r_mcand : '0;
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_next = w_last ? (r_prod - w_term) : (r_prod + w_term);

    // Product/Valid present the result of the iteration happening at this edge.
    assign Product = signed'(w_next);
    assign Valid   = r_run && w_last;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (Load) begin
            r_mcand  <= {{WIDTH{A[WIDTH-1]}}, A};
            r_mplier <= B;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_prod   <= w_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last)
                r_run <= 1'b0;
        end
    end

endmodule

// File: rtl/mac_alu.sv
// Fixed-point accumulator ALU: single-cycle load/add/sub, multi-cycle mul/mac with Start/Busy/Done.
module mac_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FRAC  = 3,
    parameter bit SAT   = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Func,
    input  logic [WIDTH-1:0] Imm,
    input  logic [WIDTH-1:0] RegData,
    input  logic [WIDTH-1:0] SW,
    input  logic             SelSW,
    input  logic             SelImm,
    output logic [WIDTH-1:0] ACC,
    output logic             Busy,
    output logic             Done,
    output logic             Ovf
);

    state_t           r_state;
    func_t            r_func;
    logic [WIDTH-1:0] r_acc;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    logic [WIDTH-1:0]          w_opd;
    logic                      w_is_mult;
    logic                      w_load;
    logic signed [2*WIDTH-1:0] w_product;
    logic                      w_mult_valid;
    logic signed [WIDTH-1:0]   w_acc_s;
    logic signed [WIDTH-1:0]   w_opd_s;
    logic signed [63:0]        w_acc64;
    logic signed [63:0]        w_opd64;
    logic signed [63:0]        w_mult;
    logic signed [63:0]        w_single;
    logic signed [63:0]        w_full;
    logic [WIDTH-1:0]          w_res;
    logic                      w_ovf;

    assign w_opd     = SelSW ? SW : (SelImm ? Imm : RegData);
    assign w_is_mult = (Func == MUL) || (Func == MAC);
    assign w_load    = (r_state == IDLE) && Start && w_is_mult;

    seq_mult #(.WIDTH(WIDTH)) u_mult (
        .Clock   (Clock),
        .Reset   (Reset),
        .Load    (w_load),
        .A       (w_opd),
        .B       (Imm),
        .Product (w_product),
        .Valid   (w_mult_valid)
    );

    assign w_acc_s = signed'(r_acc);
    assign w_opd_s = signed'(w_opd);
    assign w_acc64 = 64'(w_acc_s);
    assign w_opd64 = 64'(w_opd_s);
    assign w_mult  = (64'(w_product) >>> FRAC) + ((r_func == MAC) ? w_acc64 : 64'sd0);

    always_comb begin
        w_single = w_acc64;
        case (Func)
            LOAD:    w_single = w_opd64;
            ADD:     w_single = w_acc64 + w_opd64;
            SUB:     w_single = w_acc64 - w_opd64;
            default: w_single = w_acc64;
        endcase
    end

    // NOP falls through as ACC itself, which is always in range, so Ovf clears naturally.
    assign w_full = (r_state == MULT) ? w_mult : w_single;
    assign {w_ovf, w_res} = (WIDTH + 1)'(sat_w(w_full, WIDTH, SAT));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
            r_func  <= NOP;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        if (w_is_mult) begin
                            r_state <= MULT;
                            r_func  <= func_t'(Func);
                            r_busy  <= 1'b1;
                        end else begin
                            r_acc  <= w_res;
                            r_ovf  <= w_ovf;
                            r_done <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    if (w_mult_valid) begin
                        r_state <= IDLE;
                        r_acc   <= w_res;
                        r_ovf   <= w_ovf;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ACC  = r_acc;
    assign Busy = r_busy;
    assign Done = r_done;
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_mac_alu.sv
// Directed bench for mac_alu: a saturating and a wrapping instance driven in lockstep.
module tb_mac_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [2:0] func = 3'd0;
    logic [7:0] imm = '0;
    logic [7:0] rd = '0;
    logic [7:0] sw = '0;
    logic       ssw = 1'b0;
    logic       simm = 1'b0;

    logic [7:0] acc_s, acc_w;
    logic       busy_s, busy_w, done_s, done_w, ovf_s, ovf_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mac_alu #(.WIDTH(8), .FRAC(3), .SAT(1'b1)) u_sat (
        .Clock(clk), .Reset(rst), .Start(start), .Func(func), .Imm(imm),
        .RegData(rd), .SW(sw), .SelSW(ssw), .SelImm(simm),
        .ACC(acc_s), .Busy(busy_s), .Done(done_s), .Ovf(ovf_s)
    );

    mac_alu #(.WIDTH(8), .FRAC(3), .SAT(1'b0)) u_wrap (
        .Clock(clk), .Reset(rst), .Start(start), .Func(func), .Imm(imm),
        .RegData(rd), .SW(sw), .SelSW(ssw), .SelImm(simm),
        .ACC(acc_w), .Busy(busy_w), .Done(done_w), .Ovf(ovf_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f, input logic [7:0] v_sw, input logic [7:0] v_rd,
                         input logic [7:0] v_imm, input logic v_ssw, input logic v_simm);
        func  = f;
        sw    = v_sw;
        rd    = v_rd;
        imm   = v_imm;
        ssw   = v_ssw;
        simm  = v_simm;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts sampled Busy cycles starting with the one right after issue; bounded.
    task automatic wait_busy(output int cyc);
        cyc = 0;
        while (busy_s && cyc < 20) begin
            cyc++;
            if (cyc > 1 && done_s) break;
            tick();
        end
    endtask

    initial begin
        int cyc;
        int early_done;

        // Reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_acc",  {acc_s, acc_w},   16'h0000);
        chk("rst_busy", {busy_s, busy_w}, 2'b00);
        chk("rst_done", {done_s, done_w}, 2'b00);
        chk("rst_ovf",  {ovf_s, ovf_w},   2'b00);

        // LOAD SW=5
        issue(3'd1, 8'd5, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("load5_done", {done_s, done_w}, 2'b11);
        chk("load5_acc",  {acc_s, acc_w},   16'h0505);

        // MUL RegData=-16, Imm=24 -> -384>>>3 = -48
        issue(3'd4, 8'd0, 8'hF0, 8'd24, 1'b0, 1'b0);
        chk("mul_busy_start", {busy_s, busy_w, done_s}, 3'b110);
        wait_busy(cyc);
        chk("mul_busy_cycles", 32'(cyc), 32'd8);
        chk("mul_done", {done_s, done_w, busy_s}, 3'b110);
        chk("mul_acc",  {acc_s, acc_w}, 16'hD0D0);
        chk("mul_ovf",  {ovf_s, ovf_w}, 2'b00);
        tick();
        chk("mul_done_pulse", {done_s, done_w}, 2'b00);

        // MAC truncation: 10 + (-3*3)>>>3 = 10 - 2 = 8
        issue(3'd1, 8'd10, 8'd0, 8'd0, 1'b1, 1'b0);
        issue(3'd5, 8'd0, 8'hFD, 8'd3, 1'b0, 1'b0);
        wait_busy(cyc);
        chk("mac_cycles", 32'(cyc), 32'd8);
        chk("mac_acc", {acc_s, acc_w}, 16'h0808);

        // 120 + 20: saturate to 127 / wrap to -116
        issue(3'd1, 8'd120, 8'd0, 8'd0, 1'b1, 1'b0);
        issue(3'd2, 8'd0, 8'd0, 8'd20, 1'b0, 1'b1);
        chk("add_ovf_acc", {acc_s, acc_w}, 16'h7F8C);
        chk("add_ovf_flag", {ovf_s, ovf_w}, 2'b11);
        issue(3'd3, 8'd7, 8'd0, 8'd0, 1'b1, 1'b0);
        chk("sub7_acc", {acc_s, acc_w}, 16'h7885);
        chk("sub7_ovf", {ovf_s, ovf_w}, 2'b00);

        // 127*127 = 16129, >>>3 = 2016: saturate 127 / wrap -32
        issue(3'd4, 8'd127, 8'd0, 8'd127, 1'b1, 1'b0);
        wait_busy(cyc);
        chk("mulbig_acc", {acc_s, acc_w}, 16'h7FE0);
        chk("mulbig_ovf", {ovf_s, ovf_w}, 2'b11);

        // NOP and undefined code: Done pulse, ACC held, Ovf cleared
        issue(3'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
        chk("nop_done", {done_s, done_w}, 2'b11);
        chk("nop_acc",  {acc_s, acc_w}, 16'h7FE0);
        chk("nop_ovf",  {ovf_s, ovf_w}, 2'b00);
        issue(3'd7, 8'd9, 8'd9, 8'd9, 1'b1, 1'b0);
        chk("f7_done_acc", {done_s, acc_s, acc_w}, 17'h17FE0);

        // Start while busy is ignored: 16*8 = 128 >>>3 = 16
        issue(3'd1, 8'd1, 8'd0, 8'd0, 1'b1, 1'b0);
        issue(3'd4, 8'd16, 8'd0, 8'd8, 1'b1, 1'b0);
        tick();
        issue(3'd2, 8'd50, 8'd0, 8'd50, 1'b1, 1'b0);
        chk("ign_busy", {busy_s, busy_w}, 2'b11);
        wait_busy(cyc);
        chk("ign_cycles", 32'(cyc), 32'd6);
        chk("ign_acc", {acc_s, acc_w, done_s}, 17'h02021);
        tick();
        chk("ign_noqueue", {acc_s, done_s, busy_s}, 10'h040);

        // Reset just before iteration 4 edge of a MUL
        issue(3'd4, 8'd16, 8'd0, 8'd8, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_acc",  {acc_s, acc_w}, 16'h0000);
        chk("rstmid_busy", {busy_s, busy_w, done_s, done_w}, 4'b0000);
        early_done = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_s || done_w || busy_s) early_done++;
        end
        chk("rstmid_nodone", 32'(early_done), 32'd0);
        chk("rstmid_final", {acc_s, ovf_s}, 9'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
